// File: rtl/cart_boot_auth.sv
// cart_boot_auth: console-side boot handshake for the Bandai 2003 cartridge
// mapper. Holds the cartridge in reset, drives the 0x5A / 0xA5 address unlock,
// receives the 18-bit authentication frame from SO (start, 16 data LSB first,
// stop) and reports a sticky pass/fail result. All outputs are registered.
module cart_boot_auth #(
    parameter int          RST_CYCLES = 16,        // CART_RSTn low time after RSTn release (>= 1)
    parameter int          TIMEOUT    = 64,        // HUNT edges allowed before the start bit
    parameter logic [15:0] EXPECT     = 16'h28A0   // required frame payload
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        SO,
    output logic        CART_RSTn,
    output logic [7:0]  ADDR,
    output logic        ADDR_OE,
    output logic        BUSY,
    output logic        AUTH_OK,
    output logic        AUTH_FAIL,
    output logic [1:0]  FAIL_CODE,
    output logic        CTRL1_B8,
    output logic [15:0] RX_DATA
);

    localparam int RCW = $clog2(RST_CYCLES + 1);
    localparam int TW  = $clog2(TIMEOUT + 1);

    localparam logic [1:0] CODE_TIMEOUT  = 2'b01;
    localparam logic [1:0] CODE_STOP     = 2'b10;
    localparam logic [1:0] CODE_MISMATCH = 2'b11;

    localparam logic [7:0] UNLOCK_1 = 8'h5A;
    localparam logic [7:0] UNLOCK_2 = 8'hA5;

    typedef enum logic [2:0] {
        RST_HOLD,
        ACK,
        NAK,
        HUNT,
        DATA,
        STOP,
        DONE_OK,
        DONE_FAIL
    } state_t;

    state_t           state, state_d;
    logic [RCW-1:0]   rst_cnt, rst_cnt_d;
    logic [TW-1:0]    timer, timer_d, timer_inc;
    logic [3:0]       bit_cnt, bit_cnt_d;
    logic [15:0]      shreg, shreg_d;

    logic             cart_rstn_d;
    logic [7:0]       addr_d;
    logic             addr_oe_d;
    logic             busy_d;
    logic             auth_ok_d;
    logic             auth_fail_d;
    logic [1:0]       fail_code_d;
    logic             ctrl1_b8_d;
    logic [15:0]      rx_data_d;

    logic             so_bit;
    logic             take_ok;
    logic             take_fail;
    logic [1:0]       take_code;

    // SO has a board pull-up: only a driven 0 counts as 0; Z or X reads as 1.
    assign so_bit    = (SO === 1'b0) ? 1'b0 : 1'b1;

    // HUNT timer increments on each non-zero sample and saturates at TIMEOUT.
    assign timer_inc = (timer == TW'(TIMEOUT)) ? timer : timer + 1'b1;

    // Next-state and next-output logic for the whole handshake.
    always_comb begin
        // NOTE: every signal written here gets a default first so that no path
        // leaves one unassigned, which would otherwise infer a latch.
        state_d     = state;
        rst_cnt_d   = rst_cnt;
        timer_d     = timer;
        bit_cnt_d   = bit_cnt;
        shreg_d     = shreg;
        cart_rstn_d = CART_RSTn;
        addr_d      = ADDR;
        addr_oe_d   = ADDR_OE;
        busy_d      = BUSY;
        auth_ok_d   = AUTH_OK;
        auth_fail_d = AUTH_FAIL;
        fail_code_d = FAIL_CODE;
        ctrl1_b8_d  = CTRL1_B8;
        rx_data_d   = RX_DATA;
        take_ok     = 1'b0;
        take_fail   = 1'b0;
        take_code   = 2'b00;

        unique case (state)
            RST_HOLD: begin
                // Counter holds edges already seen, so the last one matches RST_CYCLES-1.
                if (rst_cnt == RCW'(RST_CYCLES - 1)) begin
                    cart_rstn_d = 1'b1;
                    addr_d      = UNLOCK_1;
                    state_d     = ACK;
                end else begin
                    rst_cnt_d = rst_cnt + 1'b1;
                end
            end

            ACK: begin
                addr_d  = UNLOCK_2;
                state_d = NAK;
            end

            NAK: begin
                addr_d  = 8'h00;
                timer_d = '0;
                state_d = HUNT;
            end

            HUNT: begin
                if (!so_bit) begin
                    bit_cnt_d = 4'd0;
                    state_d   = DATA;
                end else begin
                    timer_d = timer_inc;
                    if (timer_inc == TW'(TIMEOUT)) begin
                        take_fail = 1'b1;
                        take_code = CODE_TIMEOUT;
                    end
                end
            end

            DATA: begin
                // Right shift in at bit 15: the first bit received ends at bit 0.
                shreg_d = {so_bit, shreg[15:1]};
                if (bit_cnt == 4'd15) begin
                    state_d = STOP;
                end else begin
                    bit_cnt_d = bit_cnt + 1'b1;
                end
            end

            STOP: begin
                rx_data_d = shreg;
                if (so_bit) begin
                    take_fail = 1'b1;
                    take_code = CODE_STOP;
                end else if (shreg != EXPECT) begin
                    take_fail = 1'b1;
                    take_code = CODE_MISMATCH;
                end else begin
                    take_ok = 1'b1;
                end
            end

            // Terminal until RSTn: the mapper accepts its unlock only once per reset.
            DONE_OK, DONE_FAIL: begin
            end

            default: begin
                state_d = DONE_FAIL;
            end
        endcase

        if (take_ok) begin
            state_d     = DONE_OK;
            auth_ok_d   = 1'b1;
            ctrl1_b8_d  = 1'b1;
            busy_d      = 1'b0;
            addr_oe_d   = 1'b0;
        end

        if (take_fail) begin
            state_d     = DONE_FAIL;
            auth_fail_d = 1'b1;
            fail_code_d = take_code;
            ctrl1_b8_d  = 1'b0;
            busy_d      = 1'b0;
            addr_oe_d   = 1'b0;
        end
    end

    // State and output registers; RSTn restarts the whole handshake at once.
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state     <= RST_HOLD;
            rst_cnt   <= '0;
            timer     <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            CART_RSTn <= 1'b0;
            ADDR      <= 8'h00;
            ADDR_OE   <= 1'b1;
            BUSY      <= 1'b1;
            AUTH_OK   <= 1'b0;
            AUTH_FAIL <= 1'b0;
            FAIL_CODE <= 2'b00;
            CTRL1_B8  <= 1'b0;
            RX_DATA   <= 16'h0000;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // values computed before this edge, independent of statement order.
            state     <= state_d;
            rst_cnt   <= rst_cnt_d;
            timer     <= timer_d;
            bit_cnt   <= bit_cnt_d;
            shreg     <= shreg_d;
            CART_RSTn <= cart_rstn_d;
            ADDR      <= addr_d;
            ADDR_OE   <= addr_oe_d;
            BUSY      <= busy_d;
            AUTH_OK   <= auth_ok_d;
            AUTH_FAIL <= auth_fail_d;
            FAIL_CODE <= fail_code_d;
            CTRL1_B8  <= ctrl1_b8_d;
            RX_DATA   <= rx_data_d;
        end
    end

endmodule

// File: tb/tb_cart_boot_auth.sv
// tb_cart_boot_auth: directed bench for cart_boot_auth. A table of mapper
// frames (start delay, payload, stop bit) with hand-computed outcomes is
// replayed after a fresh reset each; a mid-frame reset sequence follows.
module tb_cart_boot_auth;

    localparam int RST_CYCLES = 16;
    localparam int TIMEOUT    = 64;

    // Edge numbers counted from RSTn release (edge 1 is the first posedge).
    localparam int R_EDGE    = RST_CYCLES;   // CART_RSTn rises
    localparam int HUNT_EDGE = R_EDGE + 3;   // first HUNT sample

    logic        CLK = 1'b0;
    logic        RSTn = 1'b0;
    logic        SO = 1'b1;
    logic        CART_RSTn;
    logic [7:0]  ADDR;
    logic        ADDR_OE;
    logic        BUSY;
    logic        AUTH_OK;
    logic        AUTH_FAIL;
    logic [1:0]  FAIL_CODE;
    logic        CTRL1_B8;
    logic [15:0] RX_DATA;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        string       name;
        int          delay;     // idle SO=1 HUNT samples before the start bit
        logic [15:0] payload;
        logic        stop_bit;
        logic        exp_ok;
        logic [1:0]  exp_code;
        logic [15:0] exp_rx;
    } vec_t;

    vec_t vecs[7];

    cart_boot_auth #(
        .RST_CYCLES (RST_CYCLES),
        .TIMEOUT    (TIMEOUT),
        .EXPECT     (16'h28A0)
    ) dut (
        .CLK       (CLK),
        .RSTn      (RSTn),
        .SO        (SO),
        .CART_RSTn (CART_RSTn),
        .ADDR      (ADDR),
        .ADDR_OE   (ADDR_OE),
        .BUSY      (BUSY),
        .AUTH_OK   (AUTH_OK),
        .AUTH_FAIL (AUTH_FAIL),
        .FAIL_CODE (FAIL_CODE),
        .CTRL1_B8  (CTRL1_B8),
        .RX_DATA   (RX_DATA)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " CART_RSTn"}, CART_RSTn, 1'b0);
        check({tag, " ADDR"},      ADDR,      8'h00);
        check({tag, " ADDR_OE"},   ADDR_OE,   1'b1);
        check({tag, " BUSY"},      BUSY,      1'b1);
        check({tag, " AUTH_OK"},   AUTH_OK,   1'b0);
        check({tag, " AUTH_FAIL"}, AUTH_FAIL, 1'b0);
        check({tag, " FAIL_CODE"}, FAIL_CODE, 2'b00);
        check({tag, " CTRL1_B8"},  CTRL1_B8,  1'b0);
        check({tag, " RX_DATA"},   RX_DATA,   16'h0000);
    endtask

    // Mapper model: SO value to present for the sample taken at edge e.
    function automatic logic so_at(input int e, input vec_t v);
        int idx;
        if (e < HUNT_EDGE + v.delay) return 1'b1;
        if (e == HUNT_EDGE + v.delay) return 1'b0;
        idx = e - (HUNT_EDGE + v.delay + 1);
        if (idx < 16) return v.payload[idx];
        if (idx == 16) return v.stop_bit;
        return 1'b1;
    endfunction

    // Assert RSTn, check reset outputs, release on a negedge.
    task automatic apply_reset(input string tag);
        SO   = 1'b1;
        RSTn = 1'b0;
        repeat (2) @(negedge CLK);
        check_reset_vals(tag);
        RSTn = 1'b1;
    endtask

    // Replay one frame from RSTn release. Returns right after abort_edge if non-zero.
    task automatic run_vec(input vec_t v, input int abort_edge);
        int done_e;
        done_e = (v.delay >= TIMEOUT) ? (HUNT_EDGE - 1 + TIMEOUT) : (HUNT_EDGE + 17 + v.delay);
        for (int e = 1; e <= done_e + 3; e++) begin
            SO = so_at(e, v);
            @(posedge CLK);
            #1;
            if (e == abort_edge) return;
            if (e == R_EDGE - 1) check({v.name, " CART_RSTn before R"}, CART_RSTn, 1'b0);
            if (e == R_EDGE) begin
                check({v.name, " CART_RSTn at R"}, CART_RSTn, 1'b1);
                check({v.name, " ADDR 5A"}, ADDR, 8'h5A);
            end
            if (e == R_EDGE + 1) check({v.name, " ADDR A5"}, ADDR, 8'hA5);
            if (e == R_EDGE + 2) check({v.name, " ADDR 00"}, ADDR, 8'h00);
            if (e == done_e - 1) check({v.name, " BUSY before done"}, BUSY, 1'b1);
            if (e == done_e || e == done_e + 3) begin
                check({v.name, " BUSY"},      BUSY,      1'b0);
                check({v.name, " ADDR_OE"},   ADDR_OE,   1'b0);
                check({v.name, " AUTH_OK"},   AUTH_OK,   v.exp_ok);
                check({v.name, " AUTH_FAIL"}, AUTH_FAIL, !v.exp_ok);
                check({v.name, " FAIL_CODE"}, FAIL_CODE, v.exp_code);
                check({v.name, " CTRL1_B8"},  CTRL1_B8,  v.exp_ok);
                check({v.name, " RX_DATA"},   RX_DATA,   v.exp_rx);
                check({v.name, " CART_RSTn held"}, CART_RSTn, 1'b1);
                check({v.name, " OK/FAIL exclusive"}, AUTH_OK & AUTH_FAIL, 1'b0);
            end
            @(negedge CLK);
        end
    endtask

    initial begin
        //          name          delay payload   stop  ok    code   rx
        vecs[0] = '{"good",        0,   16'h28A0, 1'b0, 1'b1, 2'b00, 16'h28A0};
        vecs[1] = '{"mismatch",    0,   16'h1234, 1'b0, 1'b0, 2'b11, 16'h1234};
        vecs[2] = '{"stop_err",    0,   16'h28A0, 1'b1, 1'b0, 2'b10, 16'h28A0};
        vecs[3] = '{"late_64th",   63,  16'h28A0, 1'b0, 1'b1, 2'b00, 16'h28A0};
        vecs[4] = '{"late_65th",   64,  16'h28A0, 1'b0, 1'b0, 2'b01, 16'h0000};
        vecs[5] = '{"all_ones",    5,   16'hFFFF, 1'b0, 1'b0, 2'b11, 16'hFFFF};
        vecs[6] = '{"off_by_msb",  2,   16'hA8A0, 1'b0, 1'b0, 2'b11, 16'hA8A0};

        for (int i = 0; i < 7; i++) begin
            apply_reset({vecs[i].name, " reset"});
            run_vec(vecs[i], 0);
        end

        // No cartridge: SO stays high; timeout after TIMEOUT HUNT edges.
        begin
            vec_t nc;
            nc = '{"no_cart", 1000, 16'hFFFF, 1'b1, 1'b0, 2'b01, 16'h0000};
            apply_reset("no_cart reset");
            run_vec(nc, 0);
        end

        // Reset pulse while bit 7 of the payload is being sampled.
        apply_reset("abort reset");
        run_vec(vecs[0], HUNT_EDGE + 1 + 7);
        check("abort BUSY mid-frame", BUSY, 1'b1);
        RSTn = 1'b0;
        #1;
        check_reset_vals("abort async");
        @(negedge CLK);
        check_reset_vals("abort held");
        RSTn = 1'b1;
        run_vec(vecs[0], 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
